dir_mem_plru: RTL and testbench



---
 rtl/param_pkg.sv | 33 +++
 rtl/dir_plru.sv | 40 ++++
 rtl/dp_ram_clk.sv | 30 +++
 rtl/dir_mem_plru.sv | 200 ++++++++++++++++++++
 tb/tb_dir_mem_plru.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/param_pkg.sv
// Shared parameters and types for the coherence directory.
//   op_dir_t          : directory operation requested by the coherence FSM
//   dir_plru_state_t  : directory controller states
//   DIR_PLRU_WAY_W()  : width of one way {valid, dirty, sharers, tag}
//   DIR_PLRU_DW()     : width of one RAM word (PLRU bits + all ways)
package param_pkg;

    localparam int DCACHE_TAG_WIDTH   = 20;
    localparam int DCACHE_INDEX_WIDTH = 6;

    typedef enum logic [2:0] {
        EVICT_OP,
        WRITE_BACK_OP,
        READ_OP,
        SET_RU_OP,
        SET_RC_OP
    } op_dir_t;

    typedef enum logic [1:0] {
        DIR_INIT,
        DIR_IDLE,
        DIR_LOOKUP
    } dir_plru_state_t;

    function automatic int DIR_PLRU_WAY_W(input int tag_w, input int n_cpu);
        return tag_w + n_cpu + 2;
    endfunction

    function automatic int DIR_PLRU_DW(input int ways, input int tag_w, input int n_cpu);
        return (ways - 1) + ways * DIR_PLRU_WAY_W(tag_w, n_cpu);
    endfunction

endpackage

// File: rtl/dir_plru.sv
// Combinational tree pseudo-LRU for one set.
//   tree       : current node bits, heap order (node 0 = root)
//   touch_way  : way being accessed
//   victim_way : way the current tree points at (bit 0 = go to lower half)
//   tree_next  : tree after touching touch_way (path points away from it)
module dir_plru #(
    parameter  int WAYS  = 4,
    localparam int IDX_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  tree,
    input  logic [IDX_W-1:0] touch_way,
    output logic [IDX_W-1:0] victim_way,
    output logic [WAYS-2:0]  tree_next
);

    logic [IDX_W-1:0] vnode;
    logic [IDX_W-1:0] tnode;
    logic [IDX_W-1:0] tw;
    logic             dir;

    always_comb begin
        victim_way = '0;
        tree_next  = tree;
        vnode      = '0;
        tnode      = '0;
        tw         = touch_way;
        dir        = 1'b0;
        for (int unsigned lvl = 0; lvl < IDX_W; lvl++) begin
            // Victim walk: follow node bits from root, building the way MSB first.
            victim_way = (victim_way << 1) | IDX_W'(tree[vnode]);
            vnode      = (vnode << 1) + (tree[vnode] ? IDX_W'(2) : IDX_W'(1));
            // Touch walk: each node on the path points to the other half.
            dir              = tw[IDX_W-1];
            tw               = tw << 1;
            tree_next[tnode] = ~dir;
            tnode            = (tnode << 1) + (dir ? IDX_W'(2) : IDX_W'(1));
        end
    end

endmodule

// File: rtl/dp_ram_clk.sv
// Simple dual-port synchronous RAM, one clock.
//   Port A: read-only, registered output (en_a, addr_a -> dout_a next cycle)
//   Port B: write-only (we_b, addr_b, din_b)
module dp_ram_clk #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en_a,
    input  logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en_a) begin
            dout_a <= mem[addr_a];
        end
        if (we_b) begin
            mem[addr_b] <= din_b;
        end
    end

endmodule

// File: rtl/dir_mem_plru.sv
// Set-associative coherence directory with tree PLRU replacement.
// Clears every set after reset, then serves one req per two cycles:
// IDLE issues the RAM read, LOOKUP computes result, pulses ack and
// writes the set back if anything changed.
//   clk, resetn        : clock, async active-low reset
//   req, operation     : request valid and op (held until ack)
//   index, tag, cpu_id : set, line tag, requesting CPU
//   ready_o            : high in IDLE only
//   ack                : one-cycle completion pulse
//   hit_o, sharers_o   : lookup result (sharers before update), valid with ack
//   victim_*           : displaced valid entry on conflict allocation
import param_pkg::*;

module dir_mem_plru #(
    parameter int N_CPU    = 4,
    parameter int CPU_ID_W = $clog2(N_CPU),
    parameter int TAG_W    = DCACHE_TAG_WIDTH,
    parameter int INDEX_W  = DCACHE_INDEX_WIDTH,
    parameter int WAYS     = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req,
    input  op_dir_t             operation,
    input  logic [INDEX_W-1:0]  index,
    input  logic [TAG_W-1:0]    tag,
    input  logic [CPU_ID_W-1:0] cpu_id,
    output logic                ready_o,
    output logic                ack,
    output logic                hit_o,
    output logic [N_CPU-1:0]    sharers_o,
    output logic                victim_valid_o,
    output logic [TAG_W-1:0]    victim_tag_o,
    output logic [N_CPU-1:0]    victim_sharers_o,
    output logic                victim_dirty_o
);

    localparam int DW    = DIR_PLRU_DW(WAYS, TAG_W, N_CPU);
    localparam int IDX_W = $clog2(WAYS);

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [N_CPU-1:0] sharers;
        logic [TAG_W-1:0] tag;
    } way_t;

    dir_plru_state_t state, state_next;
    logic [INDEX_W-1:0] init_cnt;

    logic               rd_en;
    logic [DW-1:0]      rd_data;
    logic               wr_en;
    logic [INDEX_W-1:0] wr_addr;
    logic [DW-1:0]      wr_data;

    way_t [WAYS-1:0]  ways_rd, ways_nx;
    logic [WAYS-2:0]  plru_rd, plru_nx, plru_touched;
    logic [IDX_W-1:0] hit_way, free_way, plru_victim, target_way;
    logic             hit, has_free, alloc_op, displace;
    logic [N_CPU-1:0] cpu_bit;

    dp_ram_clk #(
        .ADDR_W (INDEX_W),
        .DATA_W (DW)
    ) u_ram (
        .clk    (clk),
        .en_a   (rd_en),
        .addr_a (index),
        .dout_a (rd_data),
        .we_b   (wr_en),
        .addr_b (wr_addr),
        .din_b  (wr_data)
    );

    dir_plru #(
        .WAYS (WAYS)
    ) u_plru (
        .tree       (plru_rd),
        .touch_way  (target_way),
        .victim_way (plru_victim),
        .tree_next  (plru_touched)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= DIR_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == DIR_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // Lookup and set update, evaluated on the RAM word read in LOOKUP.
    always_comb begin
        {plru_rd, ways_rd} = rd_data;
        hit      = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!hit && ways_rd[i].valid && ways_rd[i].tag == tag) begin
                hit     = 1'b1;
                hit_way = IDX_W'(i);
            end
            if (!has_free && !ways_rd[i].valid) begin
                has_free = 1'b1;
                free_way = IDX_W'(i);
            end
        end

        cpu_bit    = N_CPU'(1) << cpu_id;
        alloc_op   = operation inside {READ_OP, SET_RU_OP, SET_RC_OP};
        target_way = hit ? hit_way : (has_free ? free_way : plru_victim);
        displace   = !hit && !has_free && alloc_op;

        ways_nx = ways_rd;
        plru_nx = plru_rd;
        case (operation)
            EVICT_OP: begin
                if (hit) begin
                    ways_nx[hit_way].sharers = ways_rd[hit_way].sharers & ~cpu_bit;
                    if ((ways_rd[hit_way].sharers & ~cpu_bit) == '0) begin
                        ways_nx[hit_way].valid = 1'b0;
                        ways_nx[hit_way].dirty = 1'b0;
                    end
                end
            end
            WRITE_BACK_OP: begin
                if (hit) begin
                    ways_nx[hit_way].valid   = 1'b0;
                    ways_nx[hit_way].dirty   = 1'b0;
                    ways_nx[hit_way].sharers = ways_rd[hit_way].sharers & ~cpu_bit;
                end
            end
            READ_OP: begin
                if (!hit) begin
                    ways_nx[target_way] = '{valid: 1'b1, dirty: 1'b0, sharers: '0, tag: tag};
                end
                plru_nx = plru_touched;
            end
            SET_RU_OP: begin
                ways_nx[target_way] = '{valid: 1'b1, dirty: 1'b1, sharers: cpu_bit, tag: tag};
                plru_nx = plru_touched;
            end
            SET_RC_OP: begin
                ways_nx[target_way] = '{valid: 1'b1, dirty: 1'b0,
                                       sharers: (hit ? ways_rd[hit_way].sharers : '0) | cpu_bit,
                                       tag: tag};
                plru_nx = plru_touched;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = index;
        wr_data    = {plru_nx, ways_nx};
        case (state)
            DIR_INIT: begin
                wr_en   = 1'b1;
                wr_addr = init_cnt;
                wr_data = '0;
                if (init_cnt == '1) begin
                    state_next = DIR_IDLE;
                end
            end
            DIR_IDLE: begin
                if (req) begin
                    rd_en      = 1'b1;
                    state_next = DIR_LOOKUP;
                end
            end
            DIR_LOOKUP: begin
                wr_en      = ({plru_nx, ways_nx} != rd_data);
                state_next = DIR_IDLE;
            end
            default: state_next = DIR_INIT;
        endcase
    end

    // Outputs are decoded from state so an async reset drops ack at once.
    always_comb begin
        ready_o          = (state == DIR_IDLE);
        ack              = (state == DIR_LOOKUP);
        hit_o            = ack && hit;
        sharers_o        = hit_o ? ways_rd[hit_way].sharers : '0;
        victim_valid_o   = ack && displace;
        victim_tag_o     = victim_valid_o ? ways_rd[plru_victim].tag : '0;
        victim_sharers_o = victim_valid_o ? ways_rd[plru_victim].sharers : '0;
        victim_dirty_o   = victim_valid_o ? ways_rd[plru_victim].dirty : 1'b0;
    end

endmodule

// File: tb/tb_dir_mem_plru.sv
import param_pkg::*;

module tb_dir_mem_plru;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req = 1'b0;
    op_dir_t    operation = READ_OP;
    logic [3:0] index = '0;
    logic [7:0] tag = '0;
    logic [1:0] cpu_id = '0;
    logic       ready_o, ack, hit_o, victim_valid_o, victim_dirty_o;
    logic [3:0] sharers_o, victim_sharers_o;
    logic [7:0] victim_tag_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic       r_ack, r_hit, r_vv, r_vd;
    logic [3:0] r_sh, r_vsh;
    logic [7:0] r_vtag;
    int         low_cycles;

    always #5 clk = ~clk;

    dir_mem_plru #(
        .N_CPU    (4),
        .CPU_ID_W (2),
        .TAG_W    (8),
        .INDEX_W  (4),
        .WAYS     (4)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .req              (req),
        .operation        (operation),
        .index            (index),
        .tag              (tag),
        .cpu_id           (cpu_id),
        .ready_o          (ready_o),
        .ack              (ack),
        .hit_o            (hit_o),
        .sharers_o        (sharers_o),
        .victim_valid_o   (victim_valid_o),
        .victim_tag_o     (victim_tag_o),
        .victim_sharers_o (victim_sharers_o),
        .victim_dirty_o   (victim_dirty_o)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Counts negedges with ready low, bounded.
    task automatic count_low();
        low_cycles = 0;
        while (!ready_o && low_cycles < 200) begin
            low_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) check("ready_timeout", 0, 1);
    endtask

    task automatic do_op(input op_dir_t op, input logic [3:0] idx, input logic [7:0] t,
                         input logic [1:0] c);
        wait_ready();
        req = 1'b1; operation = op; index = idx; tag = t; cpu_id = c;
        @(negedge clk);
        r_ack = ack; r_hit = hit_o; r_sh = sharers_o; r_vv = victim_valid_o;
        r_vtag = victim_tag_o; r_vsh = victim_sharers_o; r_vd = victim_dirty_o;
        check("ack", r_ack, 1);
        @(negedge clk);
        req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        check("rst_ready", ready_o, 0);
        check("rst_ack", ack, 0);
        check("rst_hit", hit_o, 0);
        check("rst_sharers", sharers_o, 0);
        check("rst_vv", victim_valid_o, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        count_low();
        check("init_low_cycles", low_cycles, 16);

        // First read after init: miss into empty set
        do_op(READ_OP, 4'd7, 8'h2A, 2'd0);
        check("rd7_hit", r_hit, 0);
        check("rd7_sh", r_sh, 0);
        check("rd7_vv", r_vv, 0);
        check("rd7_vtag", r_vtag, 0);

        // Shared line on idx 3
        do_op(SET_RC_OP, 4'd3, 8'h05, 2'd1);
        check("rc1_hit", r_hit, 0);
        do_op(SET_RC_OP, 4'd3, 8'h05, 2'd2);
        check("rc2_hit", r_hit, 1);
        check("rc2_sh", r_sh, 4'b0010);
        do_op(READ_OP, 4'd3, 8'h05, 2'd0);
        check("rc_rd_hit", r_hit, 1);
        check("rc_rd_sh", r_sh, 4'b0110);

        // Upgrade to unique, then evict the only sharer
        do_op(SET_RU_OP, 4'd3, 8'h05, 2'd3);
        check("ru_hit", r_hit, 1);
        check("ru_sh", r_sh, 4'b0110);
        do_op(READ_OP, 4'd3, 8'h05, 2'd0);
        check("ru_rd_sh", r_sh, 4'b1000);
        do_op(EVICT_OP, 4'd3, 8'h05, 2'd3);
        check("ev_hit", r_hit, 1);
        check("ev_sh", r_sh, 4'b1000);
        do_op(READ_OP, 4'd3, 8'h05, 2'd0);
        check("ev_rd_hit", r_hit, 0);
        check("ev_rd_sh", r_sh, 0);
        do_op(READ_OP, 4'd3, 8'h05, 2'd0);
        check("realloc_hit", r_hit, 1);
        check("realloc_sh", r_sh, 0);

        // Fill idx 0, PLRU victim selection
        for (int unsigned i = 1; i <= 4; i++) begin
            do_op(SET_RC_OP, 4'd0, 8'(i), 2'd0);
            check("fill_hit", r_hit, 0);
            check("fill_vv", r_vv, 0);
        end
        do_op(READ_OP, 4'd0, 8'h01, 2'd0);
        check("t1_hit", r_hit, 1);
        do_op(SET_RC_OP, 4'd0, 8'h05, 2'd0);
        check("c5_hit", r_hit, 0);
        check("c5_vv", r_vv, 1);
        check("c5_vtag", r_vtag, 8'h03);
        check("c5_vsh", r_vsh, 4'b0001);
        check("c5_vd", r_vd, 0);
        do_op(READ_OP, 4'd0, 8'h05, 2'd0);
        check("t5_hit", r_hit, 1);
        check("t5_sh", r_sh, 4'b0001);
        // Dirty victim: make way3 unique, touch way2 then way0 so way3 is next
        do_op(SET_RU_OP, 4'd0, 8'h04, 2'd2);
        check("t4_ru_hit", r_hit, 1);
        do_op(READ_OP, 4'd0, 8'h05, 2'd0);
        do_op(READ_OP, 4'd0, 8'h01, 2'd0);
        do_op(SET_RU_OP, 4'd0, 8'h06, 2'd1);
        check("c6_hit", r_hit, 0);
        check("c6_sh", r_sh, 0);
        check("c6_vv", r_vv, 1);
        check("c6_vtag", r_vtag, 8'h04);
        check("c6_vsh", r_vsh, 4'b0100);
        check("c6_vd", r_vd, 1);

        // Write-back miss leaves idx 2 intact
        do_op(SET_RC_OP, 4'd2, 8'h11, 2'd0);
        do_op(SET_RU_OP, 4'd2, 8'h12, 2'd1);
        do_op(WRITE_BACK_OP, 4'd2, 8'h09, 2'd0);
        check("wb_miss_hit", r_hit, 0);
        check("wb_miss_sh", r_sh, 0);
        check("wb_miss_vv", r_vv, 0);
        do_op(READ_OP, 4'd2, 8'h11, 2'd0);
        check("wb_t11_hit", r_hit, 1);
        check("wb_t11_sh", r_sh, 4'b0001);
        do_op(READ_OP, 4'd2, 8'h12, 2'd0);
        check("wb_t12_hit", r_hit, 1);
        check("wb_t12_sh", r_sh, 4'b0010);
        do_op(READ_OP, 4'd2, 8'h13, 2'd0);
        check("wb_t13_hit", r_hit, 0);
        check("wb_t13_vv", r_vv, 0);
        do_op(WRITE_BACK_OP, 4'd2, 8'h12, 2'd1);
        check("wb_hit", r_hit, 1);
        check("wb_hit_sh", r_sh, 4'b0010);
        do_op(READ_OP, 4'd2, 8'h12, 2'd0);
        check("wb_after_hit", r_hit, 0);

        // Reset during LOOKUP
        wait_ready();
        req = 1'b1; operation = READ_OP; index = 4'd7; tag = 8'h2A; cpu_id = 2'd0;
        @(negedge clk);
        check("mid_ack_before", ack, 1);
        check("mid_hit_before", hit_o, 1);
        resetn = 1'b0;
        req = 1'b0;
        #1;
        check("mid_ack_drop", ack, 0);
        check("mid_ready", ready_o, 0);
        check("mid_hit_drop", hit_o, 0);
        @(negedge clk);
        resetn = 1'b1;
        count_low();
        check("resweep_low_cycles", low_cycles, 16);
        do_op(READ_OP, 4'd7, 8'h2A, 2'd0);
        check("post_rst_hit", r_hit, 0);
        check("post_rst_vv", r_vv, 0);
        do_op(READ_OP, 4'd3, 8'h05, 2'd0);
        check("post_rst_hit3", r_hit, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
